// File: rtl/uart_rx_ovs_if.sv
// Output side of the oversampling UART receiver: received word, status flags and handshake.
// A word transfers on every clock where rx_valid && rx_ready; rx_data and flags hold while rx_valid is high.
interface uart_rx_ovs_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 brk;
    logic                 overrun;

    modport master (
        output rx_data, rx_valid, parity_err, frame_err, brk, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, parity_err, frame_err, brk, overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_ovs.sv
// 16x oversampling UART receiver with 3-sample majority vote, runtime baud divisor,
// configurable frame format and a valid/ready output with parity/framing/break/overrun status.
module uart_rx_ovs #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DIV_W     = 12
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [DIV_W-1:0] divisor,
    input  logic             rx,
    uart_rx_ovs_if.master    rxo,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    localparam logic [3:0] NBITS = 4'(DATA_BITS);
    localparam logic       ODD   = (PARITY == 1);

    state_t state, state_next;

    logic                 rx_m, rx_s;
    logic [DIV_W-1:0]     div_sh, tick_cnt;
    logic                 tick;
    logic [3:0]           samp_cnt;
    logic                 at7, at8, at9, wrap;
    logic                 s7, s8, maj;
    logic [3:0]           bit_cnt;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 pbit_r, pe_r, fe_r, stop1_r, brk_wait;
    logic                 clr_cnt, complete;
    logic                 fe_fin, stop1_fin, brk_fin;

    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q, pe_q, fe_q, brk_q, ovr_q;

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    assign tick = (tick_cnt == div_sh - DIV_W'(1));
    assign at7  = tick && (samp_cnt == 4'd7);
    assign at8  = tick && (samp_cnt == 4'd8);
    assign at9  = tick && (samp_cnt == 4'd9);
    assign wrap = tick && (samp_cnt == 4'd15);
    assign maj  = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);

    // Divisor is only sampled while idle so a frame in flight keeps its baud rate.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_sh   <= DIV_W'(1);
            tick_cnt <= '0;
            samp_cnt <= '0;
            s7       <= 1'b1;
            s8       <= 1'b1;
        end else begin
            if (state == S_IDLE)
                div_sh <= (divisor == '0) ? DIV_W'(1) : divisor;
            if (clr_cnt || tick)
                tick_cnt <= '0;
            else
                tick_cnt <= tick_cnt + DIV_W'(1);
            if (clr_cnt)
                samp_cnt <= '0;
            else if (tick)
                samp_cnt <= samp_cnt + 4'd1;
            if (at7) s7 <= rx_s;
            if (at8) s8 <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        clr_cnt    = 1'b0;
        complete   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!brk_wait && !rx_s) begin
                    clr_cnt    = 1'b1;
                    state_next = S_START;
                end
            end
            S_START: begin
                if (at9 && maj)  state_next = S_IDLE;
                else if (wrap)   state_next = S_DATA;
            end
            S_DATA: begin
                if (wrap && bit_cnt == NBITS)
                    state_next = (PARITY != 0) ? S_PAR : S_STOP;
            end
            S_PAR: begin
                if (wrap) state_next = S_STOP;
            end
            S_STOP: begin
                // Finishing at mid stop bit leaves half a bit to catch a back-to-back start.
                if (at9 && (STOP_BITS == 1 || stop_cnt)) begin
                    complete   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign fe_fin    = fe_r | ~maj;
    assign stop1_fin = stop_cnt ? stop1_r : maj;
    assign brk_fin   = (shreg == '0) && (PARITY == 0 || !pbit_r) && !stop1_fin;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shreg    <= '0;
            pbit_r   <= 1'b0;
            pe_r     <= 1'b0;
            fe_r     <= 1'b0;
            stop1_r  <= 1'b1;
            brk_wait <= 1'b0;
        end else begin
            if (clr_cnt) begin
                bit_cnt  <= '0;
                stop_cnt <= 1'b0;
                pbit_r   <= 1'b0;
                pe_r     <= 1'b0;
                fe_r     <= 1'b0;
                stop1_r  <= 1'b1;
            end else begin
                if (state == S_DATA && at9) begin
                    shreg   <= {maj, shreg[DATA_BITS-1:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
                if (state == S_PAR && at9) begin
                    pbit_r <= maj;
                    pe_r   <= (^shreg) ^ maj ^ ODD;
                end
                if (state == S_STOP && at9 && !stop_cnt) begin
                    stop1_r <= maj;
                    fe_r    <= fe_r | ~maj;
                end
                if (state == S_STOP && wrap)
                    stop_cnt <= 1'b1;
            end
            // A held-low line must return high before another start can be armed.
            if (complete && brk_fin)
                brk_wait <= 1'b1;
            else if (state == S_IDLE && rx_s)
                brk_wait <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            brk_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (complete) begin
                if (!valid_q || rxo.rx_ready) begin
                    data_q  <= shreg;
                    pe_q    <= pe_r;
                    fe_q    <= fe_fin;
                    brk_q   <= brk_fin;
                    valid_q <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && rxo.rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rxo.rx_data    = data_q;
    assign rxo.rx_valid   = valid_q;
    assign rxo.parity_err = pe_q;
    assign rxo.frame_err  = fe_q;
    assign rxo.brk        = brk_q;
    assign rxo.overrun    = ovr_q;
    assign dbg_state      = state;

endmodule
